// File: rtl/rpn_sequencer_if.sv
// Command and stack bus for rpn_sequencer.
// master: the sequencer side (drives stack strobes, status and cmd_ready).
// slave:  the environment side (issues commands and supplies stack state).
interface rpn_sequencer_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] stk_top;
  logic [W-1:0] stk_next;
  logic [7:0]   stk_count;
  logic         stk_push;
  logic         stk_pop;
  logic [W-1:0] stk_val;
  logic         done;
  logic [W-1:0] result;
  logic         err;
  logic [1:0]   err_code;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, stk_top, stk_next, stk_count,
    output cmd_ready, stk_push, stk_pop, stk_val, done, result, err, err_code
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, stk_top, stk_next, stk_count,
    input  cmd_ready, stk_push, stk_pop, stk_val, done, result, err, err_code
  );
endinterface

// File: rtl/rpn_sequencer.sv
// RPN command sequencer: sole driver of the hardware stack. Each accepted
// command becomes a fixed series of single-cycle pop/push strobes followed by
// a one-cycle DONE with result and error status.
// Optional feature: define RPN_MUL_EN to make opcode 10 a MUL (low W bits of
// next*top); otherwise opcode 10 is illegal and no multiplier exists.
module rpn_sequencer #(
  parameter int DEPTH = 31,
  parameter int W     = 16
) (
  input logic           clk,
  input logic           rst,
  rpn_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_PUSH = 4'd1,
    OP_DROP = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_DUP  = 4'd8,
    OP_SWAP = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP_A,
    S_POP_B,
    S_PUSH_R,
    S_PUSH_2,
    S_DONE
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;
  localparam logic [7:0] DEPTH_C     = 8'(DEPTH);

  state_e       state, state_nx;
  logic [3:0]   op_q;
  logic [W-1:0] imm_q, a_q, b_q;
  logic [W-1:0] result_q;
  logic [1:0]   code_q;
  logic [1:0]   code_in;
  logic [W-1:0] r;
  logic         accept;

  // Two-operand ops: pop top (a) and next (b), push b op a.
  function automatic logic is_binop(input logic [3:0] op);
    logic hit;
    hit = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
          (op == OP_OR)  || (op == OP_XOR);
`ifdef RPN_MUL_EN
    hit = hit || (op == OP_MUL);
`endif
    return hit;
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
`ifdef RPN_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_SWAP;
`endif
  endfunction

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // Precondition check on the command being offered; illegal wins over stack limits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    code_in = ERR_NONE;
    if (!is_legal(bus.cmd_op))
      code_in = ERR_ILLEGAL;
    else if ((is_binop(bus.cmd_op) || bus.cmd_op == OP_SWAP) && bus.stk_count < 8'd2)
      code_in = ERR_UNDER;
    else if ((bus.cmd_op == OP_DROP || bus.cmd_op == OP_DUP) && bus.stk_count < 8'd1)
      code_in = ERR_UNDER;
    else if ((bus.cmd_op == OP_PUSH || bus.cmd_op == OP_DUP) && bus.stk_count >= DEPTH_C)
      code_in = ERR_OVER;
  end

  // Value to push, always formed from the operands latched at acceptance.
  always_comb begin
    r = '0;
    case (op_q)
      OP_PUSH:          r = imm_q;
      OP_ADD:           r = b_q + a_q;
      OP_SUB:           r = b_q - a_q;
      OP_AND:           r = b_q & a_q;
      OP_OR:            r = b_q | a_q;
      OP_XOR:           r = b_q ^ a_q;
      OP_DUP, OP_SWAP:  r = a_q;
`ifdef RPN_MUL_EN
      OP_MUL:           r = b_q * a_q;
`endif
      default:          r = '0;
    endcase
  end

  // Next-state decode: the command picks its strobe sequence at acceptance.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (code_in != ERR_NONE) begin
            state_nx = S_DONE;
          end else begin
            case (bus.cmd_op)
              OP_NOP:          state_nx = S_DONE;
              OP_PUSH, OP_DUP: state_nx = S_PUSH_R;
              default:         state_nx = S_POP_A;
            endcase
          end
        end
      end
      S_POP_A:  state_nx = (op_q == OP_DROP) ? S_DONE : S_POP_B;
      S_POP_B:  state_nx = S_PUSH_R;
      S_PUSH_R: state_nx = (op_q == OP_SWAP) ? S_PUSH_2 : S_DONE;
      S_PUSH_2: state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Moore output decode; cmd_ready is additionally held low while in reset.
  always_comb begin
    bus.cmd_ready = (state == S_IDLE) && !rst;
    bus.stk_pop   = (state == S_POP_A) || (state == S_POP_B);
    bus.stk_push  = (state == S_PUSH_R) || (state == S_PUSH_2);
    bus.stk_val   = '0;
    if (state == S_PUSH_R) bus.stk_val = r;
    if (state == S_PUSH_2) bus.stk_val = b_q;
    bus.done      = (state == S_DONE);
    bus.err_code  = (state == S_DONE) ? code_q : ERR_NONE;
    bus.err       = (state == S_DONE) && (code_q != ERR_NONE);
    bus.result    = result_q;
  end

  // State, operand latches and result register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: operand latches are reset too, because a, b and result have defined reset values.
      state    <= S_IDLE;
      op_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      code_q   <= ERR_NONE;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= bus.cmd_op;
        imm_q  <= bus.cmd_data;
        a_q    <= bus.stk_top;
        b_q    <= bus.stk_next;
        code_q <= code_in;
      end
      // Only sequences that actually strobed reach DONE from a non-IDLE state;
      // NOP and rejected commands leave result untouched.
      if (state_nx == S_DONE && state != S_IDLE)
        result_q <= (op_q == OP_DROP) ? a_q : r;
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural 32-entry stack model.
module tb_rpn_sequencer;
  localparam int W     = 16;
  localparam int DEPTH = 31;

  logic clk = 1'b0;
  logic rst;

  rpn_sequencer_if #(.W(W)) bus();

  rpn_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stack model: driven only by the sequencer strobes, reset by the same rst.
  logic [W-1:0] mem [0:31];
  logic [5:0]   cnt;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 6'd0;
    end else if (bus.stk_push && cnt < 6'd32) begin
      mem[cnt[4:0]] <= bus.stk_val;
      cnt           <= cnt + 6'd1;
    end else if (bus.stk_pop && cnt > 6'd0) begin
      cnt <= cnt - 6'd1;
    end
  end

  always_comb begin
    bus.stk_top   = (cnt >= 6'd1) ? mem[5'(cnt - 6'd1)] : '0;
    bus.stk_next  = (cnt >= 6'd2) ? mem[5'(cnt - 6'd2)] : '0;
    bus.stk_count = 8'(cnt);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observations from the most recent command.
  int           lat;
  int           seq;
  int           npush;
  logic         got_err;
  logic [1:0]   got_code;
  logic [W-1:0] pv0, pv1;

  // Issue one command from IDLE and record strobes until done (bounded).
  // seq packs strobes in order as base-4 digits: pop=1, push=2 (3 = both at once).
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [W-1:0] data);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    check({tag, ".ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    lat = 0; seq = 0; npush = 0; got_err = 1'b0; got_code = 2'b00; pv0 = '0; pv1 = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.stk_push || bus.stk_pop)
        seq = seq * 4 + (bus.stk_pop ? 1 : 0) + (bus.stk_push ? 2 : 0);
      if (bus.stk_push) begin
        if (npush == 0) pv0 = bus.stk_val;
        else            pv1 = bus.stk_val;
        npush++;
      end
      if (bus.done) begin
        lat      = cyc;
        got_err  = bus.err;
        got_code = bus.err_code;
        break;
      end
    end
    if (lat == 0) check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [W-1:0] data,
                        input int exp_lat, input logic [1:0] exp_code, input int exp_seq);
    run_cmd(tag, op, data);
    check({tag, ".lat"},  32'(lat),      32'(exp_lat));
    check({tag, ".err"},  32'(got_err),  32'(exp_code != 2'b00));
    check({tag, ".code"}, 32'(got_code), 32'(exp_code));
    check({tag, ".seq"},  32'(seq),      32'(exp_seq));
  endtask

  task automatic check_stack(input string tag, input int exp_count, input logic [W-1:0] exp_top);
    check({tag, ".count"}, 32'(bus.stk_count), 32'(exp_count));
    if (exp_count > 0) check({tag, ".top"}, 32'(bus.stk_top), 32'(exp_top));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;

    // Reset behaviour.
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(bus.cmd_ready), 32'd0);
    check("rst.done",  32'(bus.done),      32'd0);
    check("rst.push",  32'(bus.stk_push),  32'd0);
    check("rst.pop",   32'(bus.stk_pop),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.ready",  32'(bus.cmd_ready), 32'd1);
    check("idle.result", 32'(bus.result),    32'd0);
    check("idle.code",   32'(bus.err_code),  32'd0);

    // PUSH 5, PUSH 3, SUB -> 5 - 3 = 2.
    do_cmd("push5", 4'd1, 16'h0005, 2, 2'b00, 2);
    check("push5.val", 32'(pv0), 32'h0005);
    do_cmd("push3", 4'd1, 16'h0003, 2, 2'b00, 2);
    do_cmd("sub", 4'd4, 16'h0000, 4, 2'b00, 22);
    check("sub.val", 32'(pv0), 32'h0002);
    check_stack("sub", 1, 16'h0002);
    check("sub.result", 32'(bus.result), 32'h0002);

    do_cmd("drop1", 4'd2, 16'h0000, 2, 2'b00, 1);
    check_stack("drop1", 0, 16'h0000);
    check("drop1.result", 32'(bus.result), 32'h0002);
    do_cmd("dup_empty", 4'd8, 16'h0000, 1, 2'b01, 0);
    check_stack("dup_empty", 0, 16'h0000);

    // ADD wraps, then SWAP underflows at count 1.
    do_cmd("p1234", 4'd1, 16'h1234, 2, 2'b00, 2);
    do_cmd("pffff", 4'd1, 16'hFFFF, 2, 2'b00, 2);
    do_cmd("add", 4'd3, 16'h0000, 4, 2'b00, 22);
    check_stack("add", 1, 16'h1233);
    check("add.result", 32'(bus.result), 32'h1233);
    do_cmd("swap_under", 4'd9, 16'h0000, 1, 2'b01, 0);
    check_stack("swap_under", 1, 16'h1233);
    do_cmd("drop2", 4'd2, 16'h0000, 2, 2'b00, 1);
    check("drop2.result", 32'(bus.result), 32'h1233);

    // SWAP: pop, pop, push 0xB, push 0xA.
    do_cmd("pA", 4'd1, 16'h000A, 2, 2'b00, 2);
    do_cmd("pB", 4'd1, 16'h000B, 2, 2'b00, 2);
    do_cmd("swap", 4'd9, 16'h0000, 5, 2'b00, 90);
    check("swap.pv0", 32'(pv0), 32'h000B);
    check("swap.pv1", 32'(pv1), 32'h000A);
    check_stack("swap", 2, 16'h000A);
    check("swap.next",   32'(bus.stk_next), 32'h000B);
    check("swap.result", 32'(bus.result),   32'h000B);

    // Fill 2 -> 31; the last push starts at count DEPTH-1.
    for (int i = 0; i < 29; i++)
      do_cmd("fill", 4'd1, 16'(16'h1000 + i), 2, 2'b00, 2);
    check_stack("full", 31, 16'h101C);
    do_cmd("push_over", 4'd1, 16'hDEAD, 1, 2'b10, 0);
    check_stack("push_over", 31, 16'h101C);
    do_cmd("dup_over", 4'd8, 16'h0000, 1, 2'b10, 0);
    check_stack("dup_over", 31, 16'h101C);
    do_cmd("drop_full", 4'd2, 16'h0000, 2, 2'b00, 1);
    check("drop_full.result", 32'(bus.result), 32'h101C);
    check_stack("drop_full", 30, 16'h101B);

    // Bitwise ops near the top of the stack.
    do_cmd("p0ff0", 4'd1, 16'h0FF0, 2, 2'b00, 2);
    do_cmd("and", 4'd5, 16'h0000, 4, 2'b00, 22);
    check_stack("and", 30, 16'h0010);
    do_cmd("p00ff", 4'd1, 16'h00FF, 2, 2'b00, 2);
    do_cmd("or", 4'd6, 16'h0000, 4, 2'b00, 22);
    check_stack("or", 30, 16'h00FF);
    do_cmd("p0f0f", 4'd1, 16'h0F0F, 2, 2'b00, 2);
    do_cmd("xor", 4'd7, 16'h0000, 4, 2'b00, 22);
    check_stack("xor", 30, 16'h0FF0);
    check("xor.result", 32'(bus.result), 32'h0FF0);
    do_cmd("dup", 4'd8, 16'h0000, 2, 2'b00, 2);
    check("dup.val", 32'(pv0), 32'h0FF0);
    check_stack("dup", 31, 16'h0FF0);
    check("dup.next", 32'(bus.stk_next), 32'h0FF0);

    // NOP and illegal opcodes leave stack and result untouched.
    do_cmd("nop", 4'd0, 16'h0000, 1, 2'b00, 0);
    check("nop.result", 32'(bus.result), 32'h0FF0);
    do_cmd("ill_f", 4'hF, 16'h0000, 1, 2'b11, 0);
    do_cmd("ill_c", 4'hC, 16'h0000, 1, 2'b11, 0);
    check_stack("ill", 31, 16'h0FF0);
    check("ill.result", 32'(bus.result), 32'h0FF0);

    // Opcode 10: MUL when enabled, illegal otherwise.
    do_cmd("d1", 4'd2, 16'h0000, 2, 2'b00, 1);
    do_cmd("d2", 4'd2, 16'h0000, 2, 2'b00, 1);
    do_cmd("p0100", 4'd1, 16'h0100, 2, 2'b00, 2);
    do_cmd("p0300", 4'd1, 16'h0300, 2, 2'b00, 2);
`ifdef RPN_MUL_EN
    do_cmd("mul_wrap", 4'd10, 16'h0000, 4, 2'b00, 22);
    check_stack("mul_wrap", 30, 16'h0000);
    do_cmd("d3", 4'd2, 16'h0000, 2, 2'b00, 1);
    do_cmd("p7", 4'd1, 16'h0007, 2, 2'b00, 2);
    do_cmd("p6", 4'd1, 16'h0006, 2, 2'b00, 2);
    do_cmd("mul", 4'd10, 16'h0000, 4, 2'b00, 22);
    check_stack("mul", 30, 16'h002A);
    check("mul.result", 32'(bus.result), 32'h002A);
`else
    do_cmd("op10", 4'd10, 16'h0000, 1, 2'b11, 0);
    check_stack("op10", 31, 16'h0300);
`endif

    // Reset during POP_B of an ADD abandons the sequence.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd3;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("mid.pop_a", 32'(bus.stk_pop), 32'd1);
    @(negedge clk);
    check("mid.pop_b", 32'(bus.stk_pop), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid.rst_pop",    32'(bus.stk_pop),   32'd0);
    check("mid.rst_push",   32'(bus.stk_push),  32'd0);
    check("mid.rst_done",   32'(bus.done),      32'd0);
    check("mid.rst_result", 32'(bus.result),    32'd0);
    check("mid.rst_ready",  32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid.ready", 32'(bus.cmd_ready), 32'd1);
    check("mid.pop",   32'(bus.stk_pop),   32'd0);
    check("mid.done",  32'(bus.done),      32'd0);
    do_cmd("post_rst", 4'd1, 16'h005A, 2, 2'b00, 2);
    check_stack("post_rst", 1, 16'h005A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
